// File: rtl/float_seq_pkg.sv
// Shared types and helpers for the float coefficient sequencer.
//   FLEN          : floating-point word width (IEEE binary64 by default)
//   state_t       : issue FSM states
//   coef_triple_t : one {a, b, c} coefficient triple
//   is_special    : true when the exponent field is all ones (NaN or Inf)
package float_seq_pkg;

    localparam int FLEN  = 64;
    localparam int EXP_W = (FLEN == 64) ? 11 : (FLEN == 32) ? 8 : 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [FLEN-1:0] a;
        logic [FLEN-1:0] b;
        logic [FLEN-1:0] c;
    } coef_triple_t;

    function automatic logic is_special(input logic [FLEN-1:0] x);
        return &x[FLEN-2 -: EXP_W];
    endfunction

endpackage

// File: rtl/float_triple_fifo.sv
// DEPTH-entry synchronous FIFO of W-bit words (one coefficient triple each).
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   clear      synchronous flush (pointers back to zero)
//   push/pop   write/read strobes; ignored when full/empty
//   wr_data    word to write
//   rd_data    head of queue (valid when !empty)
//   full/empty queue state
//   count      number of entries held
module float_triple_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 192
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          do_push, do_pop;

    // Push looks only at full from the start of the cycle: no bypass via a pop.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/float_coef_sequencer.sv
// Assembles a serial a, b, c coefficient stream into triples, queues them,
// and issues one triple at a time to float_discriminant honouring its busy.
// Optional build macro: FLOAT_COEF_SEQ_SPECIAL_CHECK_EN drops triples that
// contain a NaN/Inf word and pulses drop_err for one cycle instead.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clear        synchronous flush of FIFO and partial triple
//   in_vld/in_ready/in_data   coefficient input handshake
//   disc_busy    busy from float_discriminant
//   arg_vld, a, b, c          one-cycle issue of a triple
//   pending      triples currently queued
//   drop_err     special-value drop pulse (0 without the macro)
module float_coef_sequencer
    import float_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_vld,
    output logic                   in_ready,
    input  logic [FLEN-1:0]        in_data,
    input  logic                   disc_busy,
    output logic                   arg_vld,
    output logic [FLEN-1:0]        a,
    output logic [FLEN-1:0]        b,
    output logic [FLEN-1:0]        c,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   drop_err
);
    logic [1:0]      word_cnt;
    logic [FLEN-1:0] hold_a, hold_b;
    state_t          state, state_nx;
    logic            load;
    logic            accept, push_try, push, pop;
    logic            full, empty;
    coef_triple_t    wr_t, rd_t;

    // Only the completing word c waits for FIFO space.
    assign in_ready = !(word_cnt == 2'd2 && full);
    assign accept   = in_vld && in_ready && !clear;
    assign push_try = accept && (word_cnt == 2'd2);
    assign wr_t     = '{a: hold_a, b: hold_b, c: in_data};
    assign pop      = (state == S_ISSUE) && !clear;
    assign arg_vld  = (state == S_ISSUE);

`ifdef FLOAT_COEF_SEQ_SPECIAL_CHECK_EN
    logic bad;
    assign bad  = is_special(hold_a) || is_special(hold_b) || is_special(in_data);
    assign push = push_try && !bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_err <= 1'b0;
        else      drop_err <= push_try && bad;
    end
`else
    assign push     = push_try;
    assign drop_err = 1'b0;
`endif

    float_triple_fifo #(.DEPTH(DEPTH), .W($bits(coef_triple_t))) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_t),
        .rd_data (rd_t),
        .full    (full),
        .empty   (empty),
        .count   (pending)
    );

    // S_GAP covers the cycle before the discriminant's busy becomes visible.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            S_IDLE:  if (!empty && !disc_busy) begin
                         state_nx = S_ISSUE;
                         load     = 1'b1;
                     end
            S_ISSUE: state_nx = S_GAP;
            S_GAP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (clear) begin
            state_nx = S_IDLE;
            load     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            word_cnt <= 2'd0;
            hold_a   <= '0;
            hold_b   <= '0;
            a        <= '0;
            b        <= '0;
            c        <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                word_cnt <= 2'd0;
            end else if (accept) begin
                case (word_cnt)
                    2'd0:    begin hold_a <= in_data; word_cnt <= 2'd1; end
                    2'd1:    begin hold_b <= in_data; word_cnt <= 2'd2; end
                    default: word_cnt <= 2'd0;
                endcase
            end
            // Capture the head as the FSM commits to issuing it.
            if (load) begin
                a <= rd_t.a;
                b <= rd_t.b;
                c <= rd_t.c;
            end
        end
    end

endmodule
